// File: rtl/gpio_in_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// gpio_in_pkg
//   Shared definitions for the GPIO input conditioner: parameter defaults,
//   the per-channel debounce state record, the Sonata switch polarity mask
//   and a helper that clamps the shared debounce limit.
//
//   No ports (package).
// -----------------------------------------------------------------------------
package gpio_in_pkg;

    // Parameter defaults used by the top level, the channel and the interface.
    localparam int unsigned DefNumCh      = 16;
    localparam int unsigned DefCntWidth   = 16;
    localparam int unsigned DefSyncStages = 2;
    localparam logic [DefNumCh-1:0] DefInvertMask = '0;

    // Polarity mask for the Sonata board inputs. The nav/user/sel switches and
    // the mikroBUS INT line are all active-low, so every channel is inverted.
    localparam logic [DefNumCh-1:0] SonataSwInvertMask = 16'hFFFF;

    // Counters are carried at this width internally; a channel masks its
    // counter down to its own CntWidth so the unused upper bits stay zero
    // and synthesise away.
    localparam int unsigned MaxCntWidth = 32;

    typedef logic [MaxCntWidth-1:0] cnt_t;

    // Per-channel debounce state: run length of differing samples and the
    // currently accepted (debounced) level.
    typedef struct packed {
        cnt_t cnt;
        logic data;
    } ch_state_t;

    // A limit of zero behaves like one: the fastest possible response.
    function automatic cnt_t eff_limit(input cnt_t limit);
        return (limit == '0) ? cnt_t'(1) : limit;
    endfunction

endpackage : gpio_in_pkg

// File: rtl/gpio_in_conditioner_if.sv
// -----------------------------------------------------------------------------
// gpio_in_conditioner_if
//   Bundles the pin, configuration and status signals of the GPIO input
//   conditioner. The conditioner sits on the slave modport; whatever drives
//   the pins and configuration (system glue or a testbench) uses master.
//
//   Signals (NumCh wide unless noted):
//     pins_i         raw asynchronous pin levels
//     ch_en_i        per-channel enable
//     db_limit_i     debounce time in cycles, CntWidth wide, shared
//     rise_irq_en_i  interrupt on debounced 0->1
//     fall_irq_en_i  interrupt on debounced 1->0
//     irq_clear_i    write-1-to-clear pulse for irq_status_o
//     data_o         debounced, polarity-corrected level
//     rise_o/fall_o  one-cycle pulses on debounced edges
//     irq_status_o   sticky per-channel interrupt status
//     irq_o          1 bit, OR of irq_status_o
// -----------------------------------------------------------------------------
interface gpio_in_conditioner_if
    import gpio_in_pkg::*;
#(
    parameter int unsigned NumCh    = DefNumCh,
    parameter int unsigned CntWidth = DefCntWidth
);

    logic [NumCh-1:0]    pins_i;
    logic [NumCh-1:0]    ch_en_i;
    logic [CntWidth-1:0] db_limit_i;
    logic [NumCh-1:0]    rise_irq_en_i;
    logic [NumCh-1:0]    fall_irq_en_i;
    logic [NumCh-1:0]    irq_clear_i;
    logic [NumCh-1:0]    data_o;
    logic [NumCh-1:0]    rise_o;
    logic [NumCh-1:0]    fall_o;
    logic [NumCh-1:0]    irq_status_o;
    logic                irq_o;

    modport master (
        output pins_i,
        output ch_en_i,
        output db_limit_i,
        output rise_irq_en_i,
        output fall_irq_en_i,
        output irq_clear_i,
        input  data_o,
        input  rise_o,
        input  fall_o,
        input  irq_status_o,
        input  irq_o
    );

    modport slave (
        input  pins_i,
        input  ch_en_i,
        input  db_limit_i,
        input  rise_irq_en_i,
        input  fall_irq_en_i,
        input  irq_clear_i,
        output data_o,
        output rise_o,
        output fall_o,
        output irq_status_o,
        output irq_o
    );

endinterface : gpio_in_conditioner_if

// File: rtl/gpio_in_conditioner_ch.sv
// -----------------------------------------------------------------------------
// gpio_in_conditioner_ch
//   One input channel: synchroniser chain, polarity correction, debounce
//   counter, registered edge pulses and a sticky interrupt bit.
//
//   Ports:
//     clk_i, rst_i     clock, synchronous active-high reset
//     pin_i            raw asynchronous pin level
//     en_i             channel enable
//     limit_i          effective debounce limit (already clamped to >= 1)
//     rise_irq_en_i    interrupt on debounced rising edge
//     fall_irq_en_i    interrupt on debounced falling edge
//     irq_clear_i      clears irq_status_o (a simultaneous set wins)
//     data_o           debounced level
//     rise_o, fall_o   one-cycle pulses, first cycle of a new data_o value
//     irq_status_o     sticky interrupt status
// -----------------------------------------------------------------------------
module gpio_in_conditioner_ch
    import gpio_in_pkg::*;
#(
    parameter int unsigned CntWidth   = DefCntWidth,
    parameter int unsigned SyncStages = DefSyncStages,
    parameter logic        Invert     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    input  logic en_i,
    input  cnt_t limit_i,
    input  logic rise_irq_en_i,
    input  logic fall_irq_en_i,
    input  logic irq_clear_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o,
    output logic irq_status_o
);

    // Keeps the counter within CntWidth bits even though it is carried wider.
    localparam cnt_t CntMask = cnt_t'({MaxCntWidth{1'b1}} >> (MaxCntWidth - CntWidth));

    logic [SyncStages-1:0] sync_q, sync_d;
    ch_state_t             state_q, state_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  irq_q, irq_d;

    logic                  cond;
    logic [MaxCntWidth:0]  cnt_inc;
    logic                  irq_set;

    // Synchroniser runs regardless of enable so a re-enabled channel sees
    // the current pin level immediately.
    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], pin_i};
    end

    assign cond = sync_q[SyncStages-1] ^ Invert;

    // One bit wider than the counter so the increment can never wrap before
    // it is compared with the limit.
    assign cnt_inc = {1'b0, state_q.cnt} + (MaxCntWidth + 1)'(1);

    // NOTE: every combinational output gets a default at the top of the
    // block, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!en_i) begin
            // Disabled: level frozen, count held at zero, no pulses.
            state_d.cnt = '0;
        end else if (cond == state_q.data) begin
            state_d.cnt = '0;
        end else if (cnt_inc >= {1'b0, limit_i}) begin
            // >= rather than == so a limit lowered below the running count
            // still takes effect on the next differing cycle.
            state_d.data = cond;
            state_d.cnt  = '0;
            rise_d       = cond;
            fall_d       = ~cond;
        end else begin
            state_d.cnt = cnt_inc[MaxCntWidth-1:0] & CntMask;
        end
    end

    // Set is evaluated after clear so a coincident set wins.
    always_comb begin
        irq_set = en_i & ((rise_q & rise_irq_en_i) | (fall_q & fall_irq_en_i));
        irq_d   = (irq_q & ~irq_clear_i) | irq_set;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous; the sync flops reset to the inactive
        // pin level so the conditioned value starts at 0 and releasing reset
        // never looks like an edge.
        if (rst_i) begin
            sync_q  <= {SyncStages{Invert}};
            state_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
        end
    end

    assign data_o       = state_q.data;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign irq_status_o = irq_q;

endmodule : gpio_in_conditioner_ch

// File: rtl/gpio_in_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_in_conditioner
//   Input conditioner for board switches, joystick and interrupt pins. Each
//   channel is synchronised, polarity-corrected, debounced, edge-detected and
//   can raise a sticky interrupt. Feeds gp_i in sonata_system.
//
//   Ports:
//     clk_i   system clock (clk_sys)
//     rst_i   synchronous, active-high reset
//     bus     gpio_in_conditioner_if.slave: pins, enables, debounce limit,
//             interrupt enables/clears in; debounced data, edge pulses,
//             interrupt status and irq_o out
// -----------------------------------------------------------------------------
module gpio_in_conditioner
    import gpio_in_pkg::*;
#(
    parameter int unsigned      NumCh      = DefNumCh,
    parameter int unsigned      CntWidth   = DefCntWidth,
    parameter int unsigned      SyncStages = DefSyncStages,
    parameter logic [NumCh-1:0] InvertMask = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    gpio_in_conditioner_if.slave  bus
);

    cnt_t             limit;
    logic [NumCh-1:0] data;
    logic [NumCh-1:0] rise;
    logic [NumCh-1:0] fall;
    logic [NumCh-1:0] irq_status;

    // The limit is shared, so clamp it once here rather than per channel.
    assign limit = eff_limit(cnt_t'(bus.db_limit_i));

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        gpio_in_conditioner_ch #(
            .CntWidth   (CntWidth),
            .SyncStages (SyncStages),
            .Invert     (InvertMask[g])
        ) u_ch (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .pin_i         (bus.pins_i[g]),
            .en_i          (bus.ch_en_i[g]),
            .limit_i       (limit),
            .rise_irq_en_i (bus.rise_irq_en_i[g]),
            .fall_irq_en_i (bus.fall_irq_en_i[g]),
            .irq_clear_i   (bus.irq_clear_i[g]),
            .data_o        (data[g]),
            .rise_o        (rise[g]),
            .fall_o        (fall[g]),
            .irq_status_o  (irq_status[g])
        );
    end

    assign bus.data_o       = data;
    assign bus.rise_o       = rise;
    assign bus.fall_o       = fall;
    assign bus.irq_status_o = irq_status;

    // OR of registered bits only, so the line cannot glitch.
    assign bus.irq_o = |irq_status;

endmodule : gpio_in_conditioner

// File: tb/tb_gpio_in_conditioner.sv
module tb_gpio_in_conditioner;
    import gpio_in_pkg::*;

    localparam int NumCh      = 16;
    localparam int CntWidth   = 16;
    localparam int SyncStages = 2;
    localparam logic [15:0] InvMask = 16'hFF00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_in_conditioner_if #(.NumCh(NumCh), .CntWidth(CntWidth)) bus ();
    gpio_in_conditioner_if #(.NumCh(NumCh), .CntWidth(CntWidth)) bus_inv ();

    gpio_in_conditioner #(
        .NumCh(NumCh), .CntWidth(CntWidth), .SyncStages(SyncStages), .InvertMask(InvMask)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    // Fully inverted instance used for the reset-release behaviour.
    gpio_in_conditioner #(
        .NumCh(NumCh), .CntWidth(CntWidth), .SyncStages(SyncStages), .InvertMask(16'hFFFF)
    ) dut_inv (
        .clk_i(clk), .rst_i(rst), .bus(bus_inv)
    );

    int checks   = 0;
    int failures = 0;
    logic [15:0] inv_mask = InvMask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cond(input int ch, input logic v);
        bus.pins_i[ch] = v ^ inv_mask[ch];
    endtask

    task automatic prepare(input int lim);
        bus.db_limit_i    = 16'(lim);
        bus.pins_i        = inv_mask;
        bus.ch_en_i       = '1;
        bus.rise_irq_en_i = '0;
        bus.fall_irq_en_i = '0;
        bus.irq_clear_i   = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- reference model ----------------
    // Pin samples are delayed SyncStages cycles through a queue; per channel
    // the model counts consecutive samples that disagree with the accepted
    // level and accepts the new level once that run reaches max(limit,1).
    logic [15:0] m_hist[$];
    logic [15:0] m_data, m_rise, m_fall, m_irq;
    int          m_run[NumCh];

    task automatic model_step();
        logic [15:0] cond;
        logic [15:0] set;
        int lim;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < SyncStages; i++) m_hist.push_back(inv_mask);
            m_data = '0; m_rise = '0; m_fall = '0; m_irq = '0;
            for (int i = 0; i < NumCh; i++) m_run[i] = 0;
        end else begin
            cond = m_hist.pop_front() ^ inv_mask;
            m_hist.push_back(bus.pins_i);
            set   = bus.ch_en_i & ((m_rise & bus.rise_irq_en_i) | (m_fall & bus.fall_irq_en_i));
            m_irq = (m_irq & ~bus.irq_clear_i) | set;
            lim   = (bus.db_limit_i == 0) ? 1 : int'(bus.db_limit_i);
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < NumCh; ch++) begin
                if (!bus.ch_en_i[ch] || cond[ch] == m_data[ch]) begin
                    m_run[ch] = 0;
                end else begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] >= lim) begin
                        m_data[ch] = cond[ch];
                        m_rise[ch] = cond[ch];
                        m_fall[ch] = ~cond[ch];
                        m_run[ch]  = 0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        int ch;
        int lim;
        int plen;     // cycles the pin is held active (>= window means held)
        int exp_lat;  // cycles from pin edge to data_o change, 0 = no change
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_inv, bad_main, first, rises, rise_first, others;
        int pulses;

        vecs[0] = '{ch: 0,  lim: 10, plen: 40, exp_lat: 12};
        vecs[1] = '{ch: 3,  lim: 10, plen: 9,  exp_lat: 0};
        vecs[2] = '{ch: 3,  lim: 10, plen: 10, exp_lat: 12};
        vecs[3] = '{ch: 1,  lim: 0,  plen: 40, exp_lat: 3};
        vecs[4] = '{ch: 1,  lim: 1,  plen: 40, exp_lat: 3};
        vecs[5] = '{ch: 9,  lim: 4,  plen: 40, exp_lat: 6};
        vecs[6] = '{ch: 12, lim: 2,  plen: 1,  exp_lat: 0};
        vecs[7] = '{ch: 12, lim: 2,  plen: 2,  exp_lat: 4};

        bus_inv.pins_i        = 16'hFFFF;
        bus_inv.ch_en_i       = '1;
        bus_inv.db_limit_i    = 16'd1;
        bus_inv.rise_irq_en_i = '1;
        bus_inv.fall_irq_en_i = '1;
        bus_inv.irq_clear_i   = '0;
        bus.pins_i        = inv_mask;
        bus.ch_en_i       = '1;
        bus.db_limit_i    = 16'd1;
        bus.rise_irq_en_i = '1;
        bus.fall_irq_en_i = '1;
        bus.irq_clear_i   = '0;

        // ---- reset release: all-high pins on an all-inverted instance ----
        repeat (3) tick();
        rst = 1'b0;
        check("reset_data", {16'h0, bus.data_o}, 32'h0);
        check("reset_irq_status", {16'h0, bus.irq_status_o}, 32'h0);
        bad_inv  = 0;
        bad_main = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if ((bus_inv.data_o | bus_inv.rise_o | bus_inv.fall_o) != 0 || bus_inv.irq_o)
                bad_inv++;
            if ((bus.data_o | bus.rise_o | bus.fall_o) != 0 || bus.irq_o)
                bad_main++;
        end
        check("reset_inv_quiet_cycles", bad_inv, 0);
        check("reset_main_quiet_cycles", bad_main, 0);

        // ---- table-driven latency / glitch cases ----
        for (int v = 0; v < 8; v++) begin
            prepare(vecs[v].lim);
            set_cond(vecs[v].ch, 1'b1);
            first = 0; rises = 0; rise_first = 0; others = 0;
            for (int c = 1; c <= 30; c++) begin
                tick();
                if (c == vecs[v].plen) set_cond(vecs[v].ch, 1'b0);
                if (bus.rise_o[vecs[v].ch]) rises++;
                if (bus.data_o[vecs[v].ch] && first == 0) begin
                    first      = c;
                    rise_first = int'(bus.rise_o[vecs[v].ch]);
                end
                if ((bus.data_o & ~(16'h1 << vecs[v].ch)) != 0) others++;
            end
            check($sformatf("vec%0d_latency", v), first, vecs[v].exp_lat);
            check($sformatf("vec%0d_rise_count", v), rises, (vecs[v].exp_lat != 0) ? 1 : 0);
            check($sformatf("vec%0d_rise_with_data", v), rise_first,
                  (vecs[v].exp_lat != 0) ? 1 : 0);
            check($sformatf("vec%0d_other_channels", v), others, 0);
        end

        // ---- lowering the limit mid-count ----
        prepare(100);
        set_cond(6, 1'b1);
        repeat (52) tick();
        check("lower_limit_before", {31'h0, bus.data_o[6]}, 32'h0);
        bus.db_limit_i = 16'd5;
        tick();
        check("lower_limit_data", {31'h0, bus.data_o[6]}, 32'h1);
        check("lower_limit_rise", {31'h0, bus.rise_o[6]}, 32'h1);

        // ---- interrupts ----
        prepare(1);
        bus.rise_irq_en_i = 16'h0004;
        set_cond(2, 1'b1);
        repeat (3) tick();
        check("irq_rise_pulse", {31'h0, bus.rise_o[2]}, 32'h1);
        check("irq_not_yet", {31'h0, bus.irq_status_o[2]}, 32'h0);
        tick();
        check("irq_status_set", {16'h0, bus.irq_status_o}, 32'h4);
        check("irq_o_set", {31'h0, bus.irq_o}, 32'h1);
        set_cond(2, 1'b0);
        for (int n = 0; n < 10 && bus.fall_o[2] !== 1'b1; n++) tick();
        check("irq_fall_seen", {31'h0, bus.fall_o[2]}, 32'h1);
        set_cond(2, 1'b1);
        for (int n = 0; n < 10 && bus.rise_o[2] !== 1'b1; n++) tick();
        check("irq_rise2_seen", {31'h0, bus.rise_o[2]}, 32'h1);
        bus.irq_clear_i = 16'h0004;
        tick();
        bus.irq_clear_i = '0;
        check("irq_set_wins", {31'h0, bus.irq_status_o[2]}, 32'h1);
        repeat (2) tick();
        bus.irq_clear_i = 16'h0004;
        tick();
        bus.irq_clear_i = '0;
        check("irq_cleared", {31'h0, bus.irq_status_o[2]}, 32'h0);
        check("irq_o_cleared", {31'h0, bus.irq_o}, 32'h0);

        // ---- disabled channel ----
        prepare(3);
        bus.ch_en_i[5] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) set_cond(5, ((i / 4) % 2) == 0);
            tick();
            if (bus.rise_o[5] || bus.fall_o[5]) pulses++;
        end
        check("disable_frozen", {31'h0, bus.data_o[5]}, 32'h0);
        check("disable_no_pulse", pulses, 0);
        bus.ch_en_i[5] = 1'b1;
        repeat (2) tick();
        check("reenable_wait", {31'h0, bus.data_o[5]}, 32'h0);
        tick();
        check("reenable_data", {31'h0, bus.data_o[5]}, 32'h1);
        check("reenable_rise", {31'h0, bus.rise_o[5]}, 32'h1);

        // ---- reset in the middle of a count ----
        prepare(2);
        bus.rise_irq_en_i = '1;
        set_cond(1, 1'b1);
        repeat (5) tick();
        check("pre_reset_irq", {31'h0, bus.irq_o}, 32'h1);
        bus.db_limit_i = 16'd100;
        set_cond(0, 1'b1);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("midreset_data", {16'h0, bus.data_o}, 32'h0);
        check("midreset_pulses", {16'h0, bus.rise_o | bus.fall_o}, 32'h0);
        check("midreset_irq_status", {16'h0, bus.irq_status_o}, 32'h0);
        check("midreset_irq_o", {31'h0, bus.irq_o}, 32'h0);
        rst = 1'b0;

        // ---- randomized run against the model ----
        prepare(3);
        for (int n = 0; n < 3000; n++) begin
            int k;
            if (n % 250 == 0) bus.db_limit_i = 16'($urandom_range(0, 6));
            if (n % 100 == 0) begin
                bus.rise_irq_en_i = 16'($urandom);
                bus.fall_irq_en_i = 16'($urandom);
            end
            for (int ch = 0; ch < NumCh; ch++)
                if ($urandom_range(0, 7) == 0) bus.pins_i[ch] = ~bus.pins_i[ch];
            if ($urandom_range(0, 31) == 0) begin
                k = int'($urandom_range(0, NumCh - 1));
                bus.ch_en_i[k] = ~bus.ch_en_i[k];
            end
            bus.irq_clear_i = 16'($urandom) & 16'($urandom) & 16'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            tick();
            check("rnd_data", {16'h0, bus.data_o}, {16'h0, m_data});
            check("rnd_rise", {16'h0, bus.rise_o}, {16'h0, m_rise});
            check("rnd_fall", {16'h0, bus.fall_o}, {16'h0, m_fall});
            check("rnd_irq_status", {16'h0, bus.irq_status_o}, {16'h0, m_irq});
            check("rnd_irq_o", {31'h0, bus.irq_o}, {31'h0, |m_irq});
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gpio_in_conditioner
